// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
// Receive-only PS/2 keyboard front end. Resynchronises and deglitches the raw
// PS/2 lines, assembles 11-bit frames on falling edges of the filtered clock,
// validates start/parity/stop, and runs a prefix decoder (E0 / F0 / E1) that
// turns the byte stream into one key event per scancode.
//
// Ports
//   clk        system clock, all state on its rising edge
//   reset      asynchronous, active-low reset
//   ps2_clk    raw PS/2 clock line (asynchronous, never driven here)
//   ps2_data   raw PS/2 data line  (asynchronous, never driven here)
//   ps2_key    [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode
//   frame_err  one-cycle pulse on a parity, start, stop or timeout error
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_REL,
    ST_EXT_REL,
    ST_SKIP
  } state_t;

  logic [1:0]        r_clkSync;
  logic [1:0]        r_dataSync;
  logic              r_filtClk;
  logic [FILT_W-1:0] r_filtCnt;
  logic [3:0]        r_bitCnt;
  logic [9:0]        r_shift;
  logic [TO_W-1:0]   r_toCnt;
  logic              r_frameDone;
  logic              r_frameOk;
  logic [7:0]        r_frameByte;
  logic              r_timeout;
  state_t            r_state;
  logic [2:0]        r_skipCnt;

  logic w_clkS;
  logic w_dataS;
  logic w_filtFlip;
  logic w_fall;
  logic w_pressed;
  logic w_ext;

  assign w_clkS  = r_clkSync[1];
  assign w_dataS = r_dataSync[1];

  // The filtered clock flips on the cycle the synchronized level has disagreed
  // for FILTER_LEN cycles in a row; that same cycle is the falling-edge event.
  assign w_filtFlip = (w_clkS != r_filtClk) && (r_filtCnt == FILT_W'(FILTER_LEN - 1));
  assign w_fall     = w_filtFlip && r_filtClk;

  assign w_pressed = !((r_state == ST_REL) || (r_state == ST_EXT_REL));
  assign w_ext     = (r_state == ST_EXT) || (r_state == ST_EXT_REL);

  // Two-flop synchronizers; reset to the idle (high) bus level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk};
      r_dataSync <= {r_dataSync[0], ps2_data};
    end
  end

  // Glitch filter: any return to agreement restarts the run-length count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filtClk <= 1'b1;
      r_filtCnt <= '0;
    end else if (w_clkS == r_filtClk) begin
      r_filtCnt <= '0;
    end else if (w_filtFlip) begin
      r_filtClk <= w_clkS;
      r_filtCnt <= '0;
    end else begin
      r_filtCnt <= r_filtCnt + 1'b1;
    end
  end

  // Frame assembly. Bits shift in from the top so that after ten samples the
  // start bit sits in [0], data in [8:1] and parity in [9]; the stop bit is
  // judged straight off the line. A falling edge always beats the timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bitCnt    <= 4'd0;
      r_shift     <= '0;
      r_toCnt     <= '0;
      r_frameDone <= 1'b0;
      r_frameOk   <= 1'b0;
      r_frameByte <= 8'h00;
      r_timeout   <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      r_timeout   <= 1'b0;
      if (w_fall) begin
        r_toCnt <= '0;
        if (r_bitCnt == 4'd10) begin
          r_bitCnt    <= 4'd0;
          r_frameDone <= 1'b1;
          r_frameOk   <= !r_shift[0] && w_dataS && (^r_shift[9:1]);
          r_frameByte <= r_shift[8:1];
        end else begin
          r_shift  <= {w_dataS, r_shift[9:1]};
          r_bitCnt <= r_bitCnt + 4'd1;
        end
      end else if (r_bitCnt != 4'd0) begin
        if (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          r_bitCnt  <= 4'd0;
          r_toCnt   <= '0;
          r_timeout <= 1'b1;
        end else begin
          r_toCnt <= r_toCnt + 1'b1;
        end
      end else begin
        r_toCnt <= '0;
      end
    end
  end

  // Byte decoder. While skipping a Pause sequence every valid byte (E1
  // included) is only counted, so the whole E1 .. 77 burst is swallowed.
  // A timeout keeps the prefix; a bad frame throws it away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_skipCnt <= 3'd0;
      ps2_key   <= 11'h000;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (r_timeout) begin
        frame_err <= 1'b1;
      end else if (r_frameDone) begin
        if (!r_frameOk) begin
          frame_err <= 1'b1;
          r_state   <= ST_IDLE;
          r_skipCnt <= 3'd0;
        end else if (r_state == ST_SKIP) begin
          r_skipCnt <= r_skipCnt - 3'd1;
          if (r_skipCnt == 3'd1) begin
            r_state <= ST_IDLE;
          end
        end else begin
          case (r_frameByte)
            8'hE1: begin
              r_state   <= ST_SKIP;
              r_skipCnt <= 3'd7;
            end
            8'h00, 8'hFF: begin
              r_state <= ST_IDLE;
            end
            8'hE0: begin
              if (r_state == ST_IDLE) begin
                r_state <= ST_EXT;
              end
            end
            8'hF0: begin
              if (r_state == ST_IDLE) begin
                r_state <= ST_REL;
              end else if (r_state == ST_EXT) begin
                r_state <= ST_EXT_REL;
              end
            end
            default: begin
              ps2_key <= {~ps2_key[10], w_pressed, w_ext, r_frameByte};
              r_state <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule
